div8_rest: RTL and testbench

DIV8_REST -- requirements
Module: div8_rest

---
 rtl/div8_rest_pkg.sv | 14 +
 rtl/div8_rest_sub9.sv | 21 ++
 rtl/div8_rest.sv | 126 ++++++++++++
 tb/tb_div8_rest.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/div8_rest_pkg.sv
// rtl/div8_rest_pkg.sv - shared constants and state encoding for the restoring divider
package div8_rest_pkg;

    localparam int WIDTH = 8;
    localparam int ITER  = 8;
    localparam logic [WIDTH-1:0] DIV0_Q = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div8_rest_sub9.sv
// rtl/div8_rest_sub9.sv - 9-bit ripple subtractor, d = x - y, borrow out of the top bit
module sub9 (
    input  logic [8:0] x,
    input  logic [8:0] y,
    output logic [8:0] d,
    output logic       borrow
);

    logic [9:0] bchain;

    assign bchain[0] = 1'b0;

    // Each stage is the borrow-chain mirror of a full-adder stage.
    for (genvar i = 0; i < 9; i++) begin : g_stage
        assign d[i]          = x[i] ^ y[i] ^ bchain[i];
        assign bchain[i + 1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bchain[i]);
    end

    assign borrow = bchain[9];

endmodule

// File: rtl/div8_rest.sv
// rtl/div8_rest.sv - 8-bit unsigned restoring divider, one quotient bit per cycle
// Zero divisor bypasses the iteration and reports q=FF, r=a, div0=1.
module div8_rest
    import div8_rest_pkg::*;
#(
    parameter int WIDTH = div8_rest_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div0
);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             div0_q, div0_d;

    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             unused_diff_msb;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dvd_step;

    // Trial subtract the divisor from the partial remainder with the next dividend bit shifted in.
    sub9 u_sub9 (
        .x      ({rem_q, dvd_q[WIDTH-1]}),
        .y      ({1'b0, dvs_q}),
        .d      (diff),
        .borrow (borrow)
    );

    // When no borrow occurs the difference is below the divisor, so its top bit is always zero.
    assign unused_diff_msb = diff[WIDTH];

    always_comb begin
        rem_step = borrow ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : diff[WIDTH-1:0];
        dvd_step = {dvd_q[WIDTH-2:0], ~borrow};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        div0_d  = div0_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d = a;
                    dvs_d = b;
                    rem_d = '0;
                    cnt_d = '0;
                    if (b == '0) begin
                        state_d = DONE;
                        q_d     = DIV0_Q;
                        r_d     = a;
                        div0_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = rem_step;
                dvd_d = dvd_step;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(ITER - 1)) begin
                    state_d = DONE;
                    q_d     = dvd_step;
                    r_d     = rem_step;
                    div0_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            div0_q  <= div0_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign q     = q_q;
    assign r     = r_q;
    assign div0  = div0_q;

endmodule

// File: tb/tb_div8_rest.sv
// tb/tb_div8_rest.sv - scoreboard bench for div8_rest
module tb_div8_rest;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       done;
    logic [7:0] q;
    logic [7:0] r;
    logic       div0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       d;
        int         acc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_done = 1'b0;

    div8_rest dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .q     (q),
        .r     (r),
        .div0  (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) begin
                chk("done_width", {31'd0, done}, 32'd0);
                chk("ready_after_done", {31'd0, ready}, 32'd1);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("q", {24'd0, q}, {24'd0, e.q});
                    chk("r", {24'd0, r}, {24'd0, e.r});
                    chk("div0", {31'd0, div0}, {31'd0, e.d});
                    chk("latency", cyc - e.acc, e.lat);
                    if (e.b != 8'd0) begin
                        chk("identity", 32'(q) * 32'(e.b) + 32'(r), {24'd0, e.a});
                        chk("r_lt_b", {31'd0, (r < e.b)}, 32'd1);
                    end
                end
            end
            prev_done = done;
        end
    end

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] eq, input logic [7:0] er, input logic ed,
                         input bit keep, input bit expect_res);
        int n;
        n = 0;
        @(negedge clk);
        a     = ia;
        b     = ib;
        start = 1'b1;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            start = 1'b0;
            return;
        end
        if (expect_res) sb.push_back('{ia, ib, eq, er, ed, cyc + 1, ed ? 0 : 8});
        @(posedge clk);
        if (!keep) begin
            #1 start = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", {24'd0, q}, 32'd0);
        chk("rst_r", {24'd0, r}, 32'd0);
        chk("rst_div0", {31'd0, div0}, 32'd0);
        rst_n = 1'b1;

        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 1'b1);
        drain();
        issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("hold_q_in_run", {24'd0, q}, 32'd14);
        chk("hold_r_in_run", {24'd0, r}, 32'd2);
        issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b0, 1'b1);
        issue(8'd42, 8'd0, 8'hFF, 8'd42, 1'b1, 1'b0, 1'b1);
        issue(8'd0, 8'd0, 8'hFF, 8'd0, 1'b1, 1'b0, 1'b1);
        issue(8'd0, 8'd1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        issue(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b0, 1'b1);
        issue(8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 1'b0, 1'b1);
        issue(8'd128, 8'd2, 8'd64, 8'd0, 1'b0, 1'b0, 1'b1);
        drain();

        // Start held high through RUN with new operands must only take effect once ready.
        issue(8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 1'b1, 1'b1);
        issue(8'd9, 8'd9, 8'd1, 8'd0, 1'b0, 1'b0, 1'b1);
        drain();

        // Reset in the middle of RUN aborts without a done pulse.
        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_q", {24'd0, q}, 32'd0);
        chk("abort_r", {24'd0, r}, 32'd0);
        chk("abort_div0", {31'd0, div0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            issue(ra, rb, ra / rb, ra % rb, 1'b0, 1'b0, 1'b1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
